// File: rtl/seq_alu8.sv
// seq_alu8: multi-cycle ALU with ADD, SUB, Booth signed MUL and non-restoring unsigned DIV.
// Ports: clk, reset (async, active low), start, op_code[1:0], operand_A/B[W-1:0] in;
//        alu_result[2W-1:0], alu_done, div_by_zero (only with ALU_DIV0_DETECT_EN) out.
module seq_alu8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op_code,
  input  logic [WIDTH-1:0]   operand_A,
  input  logic [WIDTH-1:0]   operand_B,
  output logic [2*WIDTH-1:0] alu_result,
  output logic               alu_done
`ifdef ALU_DIV0_DETECT_EN
  ,
  output logic               div_by_zero
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    ADDSUB,
    MUL_ITER,
    DIV_ITER,
    DIV_FIX,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [1:0]       op;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   r;
  logic [CW-1:0]    cnt;
  logic             dz;
  logic             start_dz;
  logic             last;

  logic [WIDTH-1:0]   as_sum;
  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     d_ext;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_r;
  logic [2*WIDTH-1:0] res_sel;

`ifdef ALU_DIV0_DETECT_EN
  assign start_dz = (op_code == 2'b11) && (operand_B == '0);
`else
  assign start_dz = 1'b0;
`endif

  assign last = (cnt == CW'(WIDTH - 1));

  // Add/sub: B inverted with carry-in for subtract.
  assign as_sum = acc[WIDTH-1:0]
                + (m ^ {WIDTH{op[0]}})
                + {{(WIDTH-1){1'b0}}, op[0]};

  // Booth accumulator is one bit wider so that
  // subtracting the most negative M cannot overflow.
  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    mul_sum = acc;
    unique case ({q[0], qm1})
      2'b01:   mul_sum = acc + m_ext;
      2'b10:   mul_sum = acc - m_ext;
      default: mul_sum = acc;
    endcase
  end

  // Non-restoring step; the sign of the old R
  // picks subtract or add of the divisor.
  assign d_ext  = {1'b0, m};
  assign div_sh = {r[WIDTH-1:0], q[WIDTH-1]};
  assign div_r  = r[WIDTH] ? (div_sh + d_ext)
                           : (div_sh - d_ext);

  always_comb begin
    res_sel = '0;
    unique case (1'b1)
      (op == 2'b11) && dz:
        res_sel = '1;
      (op == 2'b11) && !dz:
        res_sel = {r[WIDTH-1:0], q};
      op == 2'b10:
        res_sel = {acc[WIDTH-1:0], q};
      !op[1]:
        res_sel = {{WIDTH{1'b0}}, q};
      default:
        res_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          unique case (op_code)
            2'b10:   nxt = MUL_ITER;
            2'b11:   nxt = start_dz ? ADDSUB : DIV_ITER;
            default: nxt = ADDSUB;
          endcase
        end
      end
      // Divide-by-zero shares this single-cycle
      // slot, so its latency equals add/sub.
      ADDSUB:   nxt = DONE;
      MUL_ITER: nxt = last ? DONE : MUL_ITER;
      DIV_ITER: nxt = last ? DIV_FIX : DIV_ITER;
      DIV_FIX:  nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op  <= '0;
      acc <= '0;
      q   <= '0;
      qm1 <= 1'b0;
      m   <= '0;
      r   <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op  <= op_code;
            cnt <= '0;
            qm1 <= 1'b0;
            r   <= '0;
            dz  <= start_dz;
            if (op_code == 2'b10) begin
              acc <= '0;
              q   <= operand_B;
              m   <= operand_A;
            end else if (op_code == 2'b11) begin
              acc <= '0;
              q   <= operand_A;
              m   <= operand_B;
            end else begin
              acc <= {1'b0, operand_A};
              q   <= '0;
              m   <= operand_B;
            end
          end
        end
        ADDSUB: begin
          q   <= as_sum;
          acc <= '0;
        end
        MUL_ITER: begin
          acc <= {mul_sum[WIDTH], mul_sum[WIDTH:1]};
          q   <= {mul_sum[0], q[WIDTH-1:1]};
          qm1 <= q[0];
          cnt <= cnt + CW'(1);
        end
        DIV_ITER: begin
          r   <= div_r;
          q   <= {q[WIDTH-2:0], ~div_r[WIDTH]};
          cnt <= cnt + CW'(1);
        end
        DIV_FIX: begin
          if (r[WIDTH]) begin
            r <= r + d_ext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result and pulse change only on the
  // edge that closes the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result <= '0;
      alu_done   <= 1'b0;
    end else begin
      alu_done <= 1'b0;
      if (state == DONE) begin
        alu_result <= res_sel;
        alu_done   <= 1'b1;
      end
    end
  end

`ifdef ALU_DIV0_DETECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_by_zero <= 1'b0;
    end else begin
      div_by_zero <= (state == DONE) && dz;
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu8.sv
// tb_seq_alu8: directed bench for seq_alu8.
// Scoreboard queue of expected results, immediate assertions at each check.
module tb_seq_alu8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op_code;
  logic [7:0]  operand_A;
  logic [7:0]  operand_B;
  logic [15:0] alu_result;
  logic        alu_done;
`ifdef ALU_DIV0_DETECT_EN
  logic        div_by_zero;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] sb_q[$];

  seq_alu8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_code    (op_code),
    .operand_A  (operand_A),
    .operand_B  (operand_B),
    .alu_result (alu_result),
    .alu_done   (alu_done)
`ifdef ALU_DIV0_DETECT_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    int p;
    logic [7:0] qt;
    logic [7:0] rm;
    sa = a;
    sb = b;
    model = '0;
    case (op)
      2'b00: begin qt = a + b; model = {8'h00, qt}; end
      2'b01: begin qt = a - b; model = {8'h00, qt}; end
      2'b10: begin p = sa * sb; model = p[15:0]; end
      default: begin
        if (b == 0) begin
`ifdef ALU_DIV0_DETECT_EN
          model = 16'hFFFF;
`else
          model = {a, 8'hFF};
`endif
        end else begin
          qt = a / b;
          rm = a % b;
          model = {rm, qt};
        end
      end
    endcase
  endfunction

  function automatic int lat(input logic [1:0] op,
                             input logic [7:0] b);
    if (op == 2'b10) return 9;
    if (op == 2'b11) begin
`ifdef ALU_DIV0_DETECT_EN
      if (b == 0) return 2;
`endif
      return 10;
    end
    return 2;
  endfunction

  task automatic run_op(input string tag,
                        input logic [1:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input bit disturb);
    logic [15:0] exp;
    int cyc;
    bit seen;
    @(negedge clk);
    op_code   = op;
    operand_A = a;
    operand_B = b;
    start     = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    start     = 1'b0;
    operand_A = ~a;
    operand_B = ~b;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (disturb && cyc == 3) begin
        start     = 1'b1;
        op_code   = 2'b00;
        operand_A = 8'h11;
        operand_B = 8'h22;
      end
      if (disturb && cyc == 5) start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (alu_done === 1'b1) seen = 1'b1;
    end
    exp = sb_q.pop_front();
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, cyc, lat(op, b));
    chk({tag, "_res"}, 32'(alu_result), 32'(exp));
`ifdef ALU_DIV0_DETECT_EN
    chk({tag, "_dz"}, 32'(div_by_zero),
        32'(op == 2'b11 && b == 0));
`endif
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(alu_done), 32'd0);
    chk({tag, "_hold"}, 32'(alu_result), 32'(exp));
  endtask

  initial begin
    logic [15:0] exp;
    int cyc;
    bit seen;
    start     = 1'b0;
    op_code   = 2'b00;
    operand_A = 8'h00;
    operand_B = 8'h00;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", 32'(alu_result), 32'd0);
    chk("rst_done", 32'(alu_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("add",   2'b00, 8'd33,  8'd25,  1'b0);
    run_op("sub",   2'b01, 8'd30,  8'd10,  1'b0);
    run_op("subw",  2'b01, 8'd5,   8'd10,  1'b0);
    run_op("mul",   2'b10, 8'd69,  8'd6,   1'b0);
    run_op("mulng", 2'b10, 8'hFB,  8'd3,   1'b0);
    run_op("mulmn", 2'b10, 8'h80,  8'h80,  1'b0);
    run_op("mulnn", 2'b10, 8'hF9,  8'hFD,  1'b0);
    run_op("div",   2'b11, 8'd243, 8'd22,  1'b0);
    run_op("divsm", 2'b11, 8'd7,   8'd9,   1'b0);
    run_op("divmx", 2'b11, 8'd255, 8'd1,   1'b0);
    run_op("divbg", 2'b11, 8'd200, 8'd255, 1'b0);
    run_op("muldst", 2'b10, 8'd12, 8'hF6,  1'b1);
    run_op("div0",  2'b11, 8'h2A,  8'h00,  1'b0);

    // start held high: second op begins on the
    // first IDLE edge after DONE.
    @(negedge clk);
    op_code   = 2'b00;
    operand_A = 8'd1;
    operand_B = 8'd2;
    start     = 1'b1;
    sb_q.push_back(model(2'b00, 8'd1, 8'd2));
    sb_q.push_back(model(2'b00, 8'd1, 8'd2));
    @(posedge clk);
    #1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (alu_done === 1'b1) seen = 1'b1;
    end
    exp = sb_q.pop_front();
    chk("hold1_lat", cyc, 2);
    chk("hold1_res", 32'(alu_result), 32'(exp));
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (alu_done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    exp = sb_q.pop_front();
    chk("hold2_lat", cyc, 3);
    chk("hold2_res", 32'(alu_result), 32'(exp));
    repeat (2) @(posedge clk);
    #1;
    chk("hold_stop", 32'(alu_done), 32'd0);

    // reset in the middle of a divide
    @(negedge clk);
    op_code   = 2'b11;
    operand_A = 8'd100;
    operand_B = 8'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_res", 32'(alu_result), 32'd0);
    chk("rstmid_done", 32'(alu_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (alu_done === 1'b1) seen = 1'b1;
    end
    chk("rstmid_nodone", 32'(seen), 32'd0);
    chk("rstmid_keep", 32'(alu_result), 32'd0);

    run_op("post", 2'b00, 8'd200, 8'd100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
